par5_chk: RTL and testbench

Receive-side parity checker for the 5-bit parity-protected symbol stream whose parity bit is produced by a five-input XOR on the transmit side. Accepts {4 data bits, 1 parity bit} symbols over a valid/ready handshake and re-evaluates the 5-input XOR. Forwards data with a per-symbol error flag through a one-stage registered pipeline, and accumulates frame-level and global error status. Sits directly behind the link/deserialiser and ahead of the consumer of the 4-bit data.

---
 rtl/par5_pkg.sv | 27 ++
 rtl/par5_chk_if.sv | 30 +++
 rtl/par5_xor.sv | 17 +
 rtl/par5_chk.sv | 129 ++++++++++++
 tb/tb_par5_chk.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/par5_pkg.sv
// Shared definitions for the 5-bit parity-protected symbol stream.
// A symbol is {4 data bits, 1 parity bit}. The parity check is a plain
// five-input XOR compared against the configured parity sense, so the
// transmit-side generator and this checker use the same function.
package par5_pkg;

    localparam int DATA_W = 4;
    localparam int SYM_W  = DATA_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              par;
    } par5_sym_t;

    // Frame accumulator: tracks whether the frame in progress has already
    // carried a bad symbol.
    typedef enum logic {
        IN_FRAME_CLEAN = 1'b0,
        IN_FRAME_ERR   = 1'b1
    } frame_state_t;

    // 1 when the XOR of all five symbol bits differs from the parity sense.
    function automatic logic par5_err(input par5_sym_t sym, input logic odd);
        return (^sym) != odd;
    endfunction

endpackage

// File: rtl/par5_chk_if.sv
// Symbol stream interface for par5_chk.
//   IV/IR/ID/IP/IL : input symbol handshake, data, parity bit, end of frame
//   OV/OR/OD/OE/OL : output handshake, data, parity error, end of frame
//   OFE            : frame error, meaningful on OV && OL
// slave  = the checker side, master = the source/sink around it.
interface par5_chk_if;

    logic                        IV;
    logic                        IR;
    logic [par5_pkg::DATA_W-1:0] ID;
    logic                        IP;
    logic                        IL;
    logic                        OV;
    logic                        OR;
    logic [par5_pkg::DATA_W-1:0] OD;
    logic                        OE;
    logic                        OL;
    logic                        OFE;

    modport slave (
        input  IV, ID, IP, IL, OR,
        output IR, OV, OD, OE, OL, OFE
    );

    modport master (
        output IV, ID, IP, IL, OR,
        input  IR, OV, OD, OE, OL, OFE
    );

endinterface

// File: rtl/par5_xor.sv
// Combinational five-input parity evaluator.
//   sym : {data[3:0], par} symbol
//   e   : 1 when the symbol violates the parity sense ODD
// The same block drives the parity bit on the transmit side, which keeps
// generator and checker bit-for-bit consistent.
module par5_xor
    import par5_pkg::*;
#(
    parameter bit ODD = 1'b0
) (
    input  par5_sym_t sym,
    output logic      e
);

    assign e = par5_err(sym, ODD);

endmodule

// File: rtl/par5_chk.sv
// Receive-side parity checker for the 5-bit symbol stream.
// Re-evaluates symbol parity, forwards data plus a per-symbol error flag
// through a single registered stage, and keeps frame-level and global
// error status.
//   CK     : clock, rising edge
//   RSTN   : synchronous active-low reset
//   CLR    : synchronous clear of ERRCNT and STICKY
//   bus    : symbol stream (input side IV/IR/ID/IP/IL, output side
//            OV/OR/OD/OE/OL/OFE)
//   ERRCNT : saturating count of accepted bad symbols
//   STICKY : set by the first accepted bad symbol
module par5_chk
    import par5_pkg::*;
#(
    parameter bit ODD   = 1'b0,
    parameter int CNT_W = 8
) (
    input  logic             CK,
    input  logic             RSTN,
    input  logic             CLR,
    par5_chk_if.slave        bus,
    output logic [CNT_W-1:0] ERRCNT,
    output logic             STICKY
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    par5_sym_t         sym_in;
    logic              sym_err;
    logic              ready;
    logic              accept;

    logic              ov_q,     ov_d;
    logic [DATA_W-1:0] od_q,     od_d;
    logic              oe_q,     oe_d;
    logic              ol_q,     ol_d;
    logic              ofe_q,    ofe_d;
    frame_state_t      facc_q,   facc_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              sticky_q, sticky_d;

    assign sym_in = {bus.ID, bus.IP};

    par5_xor #(.ODD(ODD)) u_xor (
        .sym (sym_in),
        .e   (sym_err)
    );

    // Single output register, no skid buffer: space exists only when the
    // register is empty or is being drained this cycle. RSTN gates ready so
    // nothing is taken while the block is held in reset.
    assign ready  = RSTN && (!ov_q || bus.OR);
    assign accept = bus.IV && ready;

    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves a signal
        // unassigned; a missing default here would infer a latch.
        ov_d     = ov_q;
        od_d     = od_q;
        oe_d     = oe_q;
        ol_d     = ol_q;
        ofe_d    = ofe_q;
        facc_d   = facc_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;

        if (accept) begin
            ov_d  = 1'b1;
            od_d  = bus.ID;
            ol_d  = bus.IL;
            oe_d  = sym_err;
            // Frame error covers earlier symbols of the frame plus this one.
            ofe_d = (facc_q == IN_FRAME_ERR) || sym_err;
            if (bus.IL) begin
                facc_d = IN_FRAME_CLEAN;
            end else if (sym_err) begin
                facc_d = IN_FRAME_ERR;
            end
        end else if (ov_q && bus.OR) begin
            // Drained with nothing new: data fields keep their last value.
            ov_d = 1'b0;
        end

        // A clear wins over a same-cycle error, which is then not counted.
        if (CLR) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (accept && sym_err) begin
            sticky_d = 1'b1;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CK) begin
        // NOTE: state updates use <= so every flop samples pre-edge values
        // regardless of statement order.
        if (!RSTN) begin
            ov_q     <= 1'b0;
            od_q     <= '0;
            oe_q     <= 1'b0;
            ol_q     <= 1'b0;
            ofe_q    <= 1'b0;
            facc_q   <= IN_FRAME_CLEAN;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            ov_q     <= ov_d;
            od_q     <= od_d;
            oe_q     <= oe_d;
            ol_q     <= ol_d;
            ofe_q    <= ofe_d;
            facc_q   <= facc_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.IR  = ready;
    assign bus.OV  = ov_q;
    assign bus.OD  = od_q;
    assign bus.OE  = oe_q;
    assign bus.OL  = ol_q;
    assign bus.OFE = ofe_q;
    assign ERRCNT  = cnt_q;
    assign STICKY  = sticky_q;

endmodule

// File: tb/tb_par5_chk.sv
// Bench for par5_chk. Three instances share one stimulus stream:
//   0: even parity, 8-bit counter
//   1: even parity, 2-bit counter (saturation)
//   2: odd parity,  8-bit counter
// A behavioural model per instance predicts every output each cycle, and a
// symbol queue on instance 0 confirms nothing is lost or duplicated.
module tb_par5_chk;

    logic       CK = 1'b0;
    logic       rstn, clr, iv, ip, il, orr;
    logic [3:0] id;

    logic        obs_ov[3], obs_ir[3], obs_oe[3], obs_ol[3], obs_ofe[3], obs_st[3];
    logic [3:0]  obs_od[3];
    logic [15:0] obs_cnt[3];

    int total = 0;
    int bad   = 0;

    par5_chk_if bus[3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam bit P_ODD = (g == 2);
        localparam int P_W   = (g == 1) ? 2 : 8;
        logic [P_W-1:0] cnt_w;
        logic           st_w;

        assign bus[g].IV = iv;
        assign bus[g].ID = id;
        assign bus[g].IP = ip;
        assign bus[g].IL = il;
        assign bus[g].OR = orr;

        par5_chk #(.ODD(P_ODD), .CNT_W(P_W)) u_dut (
            .CK     (CK),
            .RSTN   (rstn),
            .CLR    (clr),
            .bus    (bus[g]),
            .ERRCNT (cnt_w),
            .STICKY (st_w)
        );

        assign obs_ov[g]  = bus[g].OV;
        assign obs_ir[g]  = bus[g].IR;
        assign obs_od[g]  = bus[g].OD;
        assign obs_oe[g]  = bus[g].OE;
        assign obs_ol[g]  = bus[g].OL;
        assign obs_ofe[g] = bus[g].OFE;
        assign obs_cnt[g] = 16'(cnt_w);
        assign obs_st[g]  = st_w;
    end

    initial forever #5 CK = ~CK;

    // ---------------- reference model ----------------
    bit         m_ov[3], m_oe[3], m_ol[3], m_ofe[3], m_facc[3], m_st[3];
    logic [3:0] m_od[3];
    int         m_cnt[3];
    logic [5:0] sb[$];

    function automatic int cmax(input int k);
        return (k == 1) ? 3 : 255;
    endfunction

    function automatic bit sym_bad(input int k, input logic [3:0] d, input logic p);
        bit want_odd;
        want_odd = (k == 2);
        return (($countones({d, p}) % 2) == 1) != want_odd;
    endfunction

    task automatic check(input string tag, input int k, input logic [15:0] obs,
                         input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_clock();
        for (int k = 0; k < 3; k++) begin
            bit acc, e;
            acc = rstn && iv && (!m_ov[k] || orr);
            e   = sym_bad(k, id, ip);
            if (!rstn) begin
                m_ov[k] = 0; m_od[k] = 0; m_oe[k] = 0; m_ol[k] = 0;
                m_ofe[k] = 0; m_facc[k] = 0; m_cnt[k] = 0; m_st[k] = 0;
            end else begin
                if (acc) begin
                    m_od[k]   = id;
                    m_ol[k]   = il;
                    m_oe[k]   = e;
                    m_ofe[k]  = m_facc[k] | e;
                    m_facc[k] = il ? 1'b0 : (m_facc[k] | e);
                    m_ov[k]   = 1;
                end else if (m_ov[k] && orr) begin
                    m_ov[k] = 0;
                end
                if (clr) begin
                    m_cnt[k] = 0;
                    m_st[k]  = 0;
                end else if (acc && e) begin
                    if (m_cnt[k] < cmax(k)) m_cnt[k]++;
                    m_st[k] = 1;
                end
            end
        end
    endtask

    // One cycle: drive inputs just after a falling edge, check IR and the
    // instance-0 queue, clock, then check all registered outputs.
    task automatic step(input bit v, input logic [3:0] d, input bit p, input bit l,
                        input bit r, input bit c, input bit rn);
        logic [5:0] exp_sym;
        iv = v; id = d; ip = p; il = l; orr = r; clr = c; rstn = rn;
        #1;
        for (int k = 0; k < 3; k++)
            check("ir", k, obs_ir[k], rn && (!m_ov[k] || r));
        if (!rn) begin
            sb.delete();
        end else begin
            if (m_ov[0] && r) begin
                check("sb_avail", 0, sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    exp_sym = sb.pop_front();
                    check("sb_sym", 0, {obs_od[0], obs_oe[0], obs_ol[0]}, exp_sym);
                end
            end
            if (v && (!m_ov[0] || r)) sb.push_back({d, sym_bad(0, d, p), l});
        end
        @(posedge CK);
        model_clock();
        @(negedge CK);
        for (int k = 0; k < 3; k++) begin
            check("ov",     k, obs_ov[k],  m_ov[k]);
            check("od",     k, obs_od[k],  m_od[k]);
            check("oe",     k, obs_oe[k],  m_oe[k]);
            check("ol",     k, obs_ol[k],  m_ol[k]);
            check("ofe",    k, obs_ofe[k], m_ofe[k]);
            check("errcnt", k, obs_cnt[k], 16'(m_cnt[k]));
            check("sticky", k, obs_st[k],  m_st[k]);
        end
    endtask

    task automatic send(input logic [3:0] d, input bit p, input bit l);
        step(1, d, p, l, 1, 0, 1);
    endtask

    initial begin
        rstn = 0; clr = 0; iv = 0; id = 0; ip = 0; il = 0; orr = 0;
        @(negedge CK);

        // Reset state, then first ready cycle.
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        check("rst_ov", 0, obs_ov[0], 0);
        check("rst_cnt", 0, obs_cnt[0], 0);
        step(0, 0, 0, 0, 1, 0, 1);

        // Even parity: 1011 with p=1 is good, with p=0 is bad.
        send(4'b1011, 1, 0);
        check("tp1_oe_good", 0, obs_oe[0], 0);
        send(4'b1011, 0, 0);
        check("tp1_oe_bad", 0, obs_oe[0], 1);
        check("tp1_cnt", 0, obs_cnt[0], 1);
        check("tp1_sticky", 0, obs_st[0], 1);
        send(4'b0000, 0, 1);

        // Backpressure: output held for three cycles with a symbol waiting.
        send(4'b0110, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 4'b1111, 0, 0, 0, 0, 1);
            check("bp_od_hold", 0, obs_od[0], 4'b0110);
        end
        send(4'b1111, 0, 0);
        check("bp_od_next", 0, obs_od[0], 4'b1111);

        // Frame with second symbol bad, then a clean frame.
        send(4'b0001, 1, 0);
        send(4'b0011, 1, 0);
        send(4'b0101, 0, 0);
        send(4'b0110, 0, 1);
        check("frm_err_ofe", 0, obs_ofe[0], 1);
        send(4'b0000, 0, 0);
        send(4'b0111, 1, 0);
        send(4'b1001, 0, 0);
        send(4'b1111, 0, 1);
        check("frm_clean_ofe", 0, obs_ofe[0], 0);

        // Saturation on the 2-bit counter, then clear against an error.
        step(0, 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            send(4'b0001, 0, 0);
            check("sat_cnt", 1, obs_cnt[1], (i < 3) ? 16'(i + 1) : 16'd3);
        end
        step(1, 4'b0001, 0, 0, 1, 1, 1);
        check("clr_cnt", 1, obs_cnt[1], 0);
        check("clr_sticky", 1, obs_st[1], 0);
        send(4'b0000, 0, 1);

        // Odd parity instance.
        send(4'b0000, 1, 1);
        check("odd_good", 2, obs_oe[2], 0);
        send(4'b0000, 0, 1);
        check("odd_bad", 2, obs_oe[2], 1);

        // Reset in the middle of a frame that already saw an error.
        send(4'b0001, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        check("mid_rst_ov", 0, obs_ov[0], 0);
        check("mid_rst_od", 0, obs_od[0], 0);
        check("mid_rst_st", 0, obs_st[0], 0);
        send(4'b0010, 1, 0);
        send(4'b0011, 0, 1);
        check("mid_rst_ofe", 0, obs_ofe[0], 0);
        check("mid_rst_ol", 0, obs_ol[0], 1);

        // Random traffic with random backpressure and occasional clears.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(3, 0) != 0, 4'($urandom), 1'($urandom),
                 $urandom_range(3, 0) == 0, $urandom_range(2, 0) != 0,
                 $urandom_range(31, 0) == 0, 1);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 1);
        check("sb_left", 0, sb.size(), m_ov[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
